// File: rtl/quat_pkg.sv
// Shared constants and width helper for the quaternion rotation pipeline.
package quat_pkg;

  localparam int QW_DEF = 32;
  localparam int QF_DEF = 30;
  localparam int GB_DEF = 14;
  localparam longint QONE = 64'sd1 <<< QF_DEF;

  // Widest intermediate: cross of the (QW+1)-bit conjugated quaternion with T,
  // plus one bit of headroom for the final three-term sum and rounding offset.
  function automatic int calc_iw(int wp, int qw, int gb);
    return 2 * qw + wp + gb + 6;
  endfunction

endpackage

// File: rtl/quat_cross3.sv
// Combinational signed 3-vector cross product c = a x b, sized so it cannot overflow.
module quat_cross3
  import quat_pkg::*;
#(
  parameter int A = QW_DEF + 1,
  parameter int B = QW_DEF + GB_DEF
) (
  input  logic signed [A-1:0] a_x,
  input  logic signed [A-1:0] a_y,
  input  logic signed [A-1:0] a_z,
  input  logic signed [B-1:0] b_x,
  input  logic signed [B-1:0] b_y,
  input  logic signed [B-1:0] b_z,
  output logic signed [A+B:0] c_x,
  output logic signed [A+B:0] c_y,
  output logic signed [A+B:0] c_z
);

  localparam int W = A + B + 1;

  assign c_x = W'(a_y) * W'(b_z) - W'(a_z) * W'(b_y);
  assign c_y = W'(a_z) * W'(b_x) - W'(a_x) * W'(b_z);
  assign c_z = W'(a_x) * W'(b_y) - W'(a_y) * W'(b_x);

endmodule

// File: rtl/quat_rotate_pipe.sv
// Three-stage pipelined rotation of a 3-vector by a unit quaternion (or its conjugate),
// v' = v + qw*T + qa x T with T = 2*(qa x v), evaluated exactly with guard bits.
module quat_rotate_pipe
  import quat_pkg::*;
#(
  parameter int WP    = 32,
  parameter int QW    = QW_DEF,
  parameter int QF    = QF_DEF,
  parameter int GB    = GB_DEF,
  parameter int TW    = 8,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_inv,
  input  logic [QW-1:0] q_w,
  input  logic [QW-1:0] q_x,
  input  logic [QW-1:0] q_y,
  input  logic [QW-1:0] q_z,
  input  logic [WP-1:0] vx,
  input  logic [WP-1:0] vy,
  input  logic [WP-1:0] vz,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WP-1:0] ox,
  output logic [WP-1:0] oy,
  output logic [WP-1:0] oz,
  output logic          out_sat,
  output logic [TW-1:0] out_tag
);

  localparam int QA   = QW + 1;
  localparam int VG   = WP + GB;
  localparam int CW1  = QA + VG + 1;
  localparam int TWID = CW1 + 1;
  localparam int CW2  = QA + TWID + 1;
  localparam int IW   = calc_iw(WP, QW, GB);
  localparam int SH   = QF + GB;
  localparam logic signed [IW-1:0] RND  = (ROUND != 0) ? (IW'(1) <<< (SH - 1)) : '0;
  localparam logic signed [IW-1:0] MAXV = $signed({{(IW-WP+1){1'b0}}, {(WP-1){1'b1}}});
  localparam logic signed [IW-1:0] MINV = $signed({{(IW-WP+1){1'b1}}, {(WP-1){1'b0}}});

  // Valid/ready: a beat moves when valid && ready. Each stage loads when it is empty
  // or its content is leaving, so a stall at the output freezes everything behind it.
  logic s1_valid, s2_valid;
  logic en1, en2, en3;

  assign en3      = !out_valid || out_ready;
  assign en2      = !s2_valid || en3;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  // Stage 1: conjugate (at QW+1 bits so the most-negative value negates cleanly) and cross.
  logic signed [QA-1:0]  qa [3];
  logic signed [VG-1:0]  vg [3];
  logic signed [CW1-1:0] c1 [3];

  always_comb begin
    qa[0] = in_inv ? -QA'($signed(q_x)) : QA'($signed(q_x));
    qa[1] = in_inv ? -QA'($signed(q_y)) : QA'($signed(q_y));
    qa[2] = in_inv ? -QA'($signed(q_z)) : QA'($signed(q_z));
    vg[0] = $signed({vx, {GB{1'b0}}});
    vg[1] = $signed({vy, {GB{1'b0}}});
    vg[2] = $signed({vz, {GB{1'b0}}});
  end

  quat_cross3 #(.A(QA), .B(VG)) u_cross1 (
    .a_x(qa[0]), .a_y(qa[1]), .a_z(qa[2]),
    .b_x(vg[0]), .b_y(vg[1]), .b_z(vg[2]),
    .c_x(c1[0]), .c_y(c1[1]), .c_z(c1[2])
  );

  logic signed [TWID-1:0] t1  [3];
  logic signed [QA-1:0]   qa1 [3];
  logic signed [WP-1:0]   v1d [3];
  logic signed [QW-1:0]   qw1;
  logic [TW-1:0]          tag1;

  // Stage 2: scale T by qw and cross again, dropping the quaternion fraction bits.
  logic signed [CW2-1:0] c2 [3];
  logic signed [IW-1:0]  wt [3];
  logic signed [IW-1:0]  cs [3];

  quat_cross3 #(.A(QA), .B(TWID)) u_cross2 (
    .a_x(qa1[0]), .a_y(qa1[1]), .a_z(qa1[2]),
    .b_x(t1[0]),  .b_y(t1[1]),  .b_z(t1[2]),
    .c_x(c2[0]),  .c_y(c2[1]),  .c_z(c2[2])
  );

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      wt[i] = (IW'(qw1) * IW'(t1[i])) >>> QF;
      cs[i] = IW'(c2[i]) >>> QF;
    end
  end

  logic signed [IW-1:0] wt2 [3];
  logic signed [IW-1:0] cs2 [3];
  logic signed [WP-1:0] v2d [3];
  logic [TW-1:0]        tag2;

  // Stage 3: recombine, round, shift out guard + fraction bits, clamp or wrap.
  function automatic logic [WP:0] finish_fn(input logic signed [IW-1:0] r);
    logic [WP:0] f;
    f = {1'b0, r[WP-1:0]};
    if (SAT != 0) begin
      if (r > MAXV)      f = {1'b1, MAXV[WP-1:0]};
      else if (r < MINV) f = {1'b1, MINV[WP-1:0]};
    end
    return f;
  endfunction

  logic signed [IW-1:0] s3 [3];
  logic [WP-1:0]        res [3];
  logic [2:0]           clip;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      s3[i] = ((IW'(v2d[i]) <<< SH) + wt2[i] + cs2[i] + RND) >>> SH;
      {clip[i], res[i]} = finish_fn(s3[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && en1) begin
      for (int i = 0; i < 3; i++) begin
        t1[i]  <= $signed({c1[i], 1'b0});
        qa1[i] <= qa[i];
      end
      v1d[0] <= $signed(vx);
      v1d[1] <= $signed(vy);
      v1d[2] <= $signed(vz);
      qw1    <= $signed(q_w);
      tag1   <= in_tag;
    end
    if (s1_valid && en2) begin
      for (int i = 0; i < 3; i++) begin
        wt2[i] <= wt[i];
        cs2[i] <= cs[i];
        v2d[i] <= v1d[i];
      end
      tag2 <= tag1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      ox        <= '0;
      oy        <= '0;
      oz        <= '0;
      out_sat   <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (en1) s1_valid <= in_valid;
      if (en2) s2_valid <= s1_valid;
      if (en3) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          ox      <= res[0];
          oy      <= res[1];
          oz      <= res[2];
          out_sat <= |clip;
          out_tag <= tag2;
        end
      end
    end
  end

endmodule
